// File: rtl/bin_to_bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// Define BCD_SIGN_EN to treat bin_in as two's complement and report the sign on `negative`.
module bin_to_bcd_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] bin_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] out_ones,
   output logic [3:0] out_tens,
   output logic [3:0] out_huns,
   output logic       negative,
   output logic       ovf
);

   localparam int unsigned BIN_W = 10;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned THO_W = 2;
   localparam int unsigned BCD_W = THO_W + 3 * DIG_W;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
   localparam logic [DIG_W-1:0] NINE      = DIG_W'(9);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               sign_q, sign_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [DIG_W-1:0]   ones_q, ones_d;
   logic [DIG_W-1:0]   tens_q, tens_d;
   logic [DIG_W-1:0]   huns_q, huns_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;

   logic [BIN_W-1:0]   mag_c;
   logic               sign_c;
   logic [BCD_W-1:0]   adj_c;

   // Magnitude and sign of the incoming value
   always_comb begin
`ifdef BCD_SIGN_EN
      sign_c = bin_in[BIN_W-1];
      mag_c  = sign_c ? (~bin_in + BIN_W'(1)) : bin_in;
`else
      sign_c = 1'b0;
      mag_c  = bin_in;
`endif
   end

   // Add-3 correction on the three low digits; the 2-bit thousands digit never reaches 5
   always_comb begin
      adj_c = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[i*DIG_W +: DIG_W] >= DIG_W'(5))
            adj_c[i*DIG_W +: DIG_W] = bcd_q[i*DIG_W +: DIG_W] + DIG_W'(3);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         sign_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ones_q  <= '0;
         tens_q  <= '0;
         huns_q  <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         sign_q  <= sign_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ones_q  <= ones_d;
         tens_q  <= tens_d;
         huns_q  <= huns_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == LAST_ITER) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      sign_d = sign_q;
      ones_d = ones_q;
      tens_d = tens_q;
      huns_d = huns_q;
      neg_d  = neg_q;
      ovf_d  = ovf_q;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d  = '0;
               bin_d  = mag_c;
               bcd_d  = '0;
               sign_d = sign_c;
            end
         end
         S_SHIFT: begin
            bcd_d = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
         end
         S_FIX: begin
            neg_d = sign_q;
            if (bcd_q[BCD_W-1 -: THO_W] != '0) begin
               huns_d = NINE;
               tens_d = NINE;
               ones_d = NINE;
               ovf_d  = 1'b1;
            end else begin
               huns_d = bcd_q[2*DIG_W +: DIG_W];
               tens_d = bcd_q[DIG_W +: DIG_W];
               ones_d = bcd_q[0 +: DIG_W];
               ovf_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign out_ones = ones_q;
   assign out_tens = tens_q;
   assign out_huns = huns_q;
   assign negative = neg_q;
   assign ovf      = ovf_q;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, system clock (CLOCK_50 domain); all state changes on posedge.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, conversion request; sampled only in IDLE.
REQ-005 Port `bin_in`: input, 10 bits, binary temperature value; captured on the accepted `start`.
REQ-006 Port `busy`: output, 1 bit, high from the cycle after an accepted `start` until `done` completes.
REQ-007 Port `done`: output, 1 bit, one-cycle pulse; results are valid from that cycle.
REQ-008 Ports `out_ones`, `out_tens`, `out_huns`: outputs, 4 bits each, BCD digits 0..9, registered.
REQ-009 Port `negative`: output, 1 bit, result sign, registered.
REQ-010 Port `ovf`: output, 1 bit, magnitude >999, registered.

Function
REQ-011 States SHALL be IDLE, SHIFT, FIX, DONE.
REQ-012 IDLE: if `start`=1 at edge k, capture `bin_in` and go to SHIFT with a shift counter of 0; otherwise stay.
REQ-013 SHIFT: one double-dabble iteration per cycle:
  - add 3 to any BCD nibble ≥5;
  - then shift left one bit, MSB of the magnitude first;
  - exactly 10 iterations, at edges k+1..k+10;
  - then go to FIX.
REQ-014 The scratch register SHALL hold 4 BCD digits (thousands digit 2 bits minimum), so 1023 converts without loss.
REQ-015 FIX, at edge k+11: go to DONE and load the output registers.
  - If thousands≠0 or the magnitude exceeds 999: load 9,9,9 and `ovf`=1.
  - Otherwise: load the converted digits and `ovf`=0.
  - Load `negative` per REQ-026/027.
REQ-016 DONE: `done`=1 and `busy`=1 for this one cycle (edge k+11 to k+12); return to IDLE at edge k+12.
REQ-017 Latency: an accepted `start` at edge k SHALL yield `done` high in the cycle after edge k+11 (12 cycles).
REQ-018 `start` asserted in SHIFT, FIX or DONE SHALL be ignored; it is not queued.
REQ-019 `bin_in` changes after capture SHALL NOT affect the conversion in progress.
REQ-020 Output registers SHALL hold the last result until the next FIX load.
REQ-021 `busy` SHALL be 0 in IDLE and 1 in SHIFT, FIX and DONE.
REQ-022 Back-to-back operation: a `start` held high SHALL be accepted again in the IDLE cycle following DONE, giving one conversion every 13 cycles.

Reset
REQ-023 `rst`=1 at any edge SHALL force IDLE and clear all of: `busy`, `done`, `out_*`, `negative`, `ovf`, the scratch register and the counter.
REQ-024 `rst` during SHIFT, FIX or DONE SHALL abort the conversion; no `done` pulse is produced for it.
REQ-025 When `rst` and `start` are high in the same cycle, `rst` SHALL win; `start` is not accepted.

Configuration
REQ-026 With macro `BCD_SIGN_EN` defined:
  - `bin_in` is two's complement, range -512..511.
  - If bit 9 is set, the magnitude (two's-complement negation) is converted and `negative`=1.
  - Otherwise `negative`=0.
  - `ovf` can never assert, since the maximum magnitude is 512.
REQ-027 With `BCD_SIGN_EN` undefined:
  - `bin_in` is unsigned, range 0..1023.
  - `negative` is tied to 0.
  - Values 1000..1023 set `ovf`=1 with digits 9,9,9.

Verification
REQ-028 The bench SHALL drive `bin_in`=0 and pulse `start`, and require `done` exactly 12 cycles later with 0,0,0, `negative`=0 and `ovf`=0.
REQ-029 The bench SHALL convert `bin_in`=255 and require huns/tens/ones = 2,5,5 and `busy` high for exactly 12 cycles.
REQ-030 The bench SHALL drive `bin_in`=10'h3FF:
  - with `BCD_SIGN_EN`: require `negative`=1 and digits 0,0,1;
  - without it: require `ovf`=1 and digits 9,9,9.
REQ-031 The bench SHALL drive `bin_in`=10'h200 with `BCD_SIGN_EN` and require `negative`=1, digits 5,1,2 and `ovf`=0.
REQ-032 The bench SHALL pulse `start` with `bin_in`=100 and pulse `start` again 5 cycles later with `bin_in`=7:
  - require exactly one `done` pulse, with digits 1,0,0;
  - the second request is ignored.
REQ-033 The bench SHALL assert `rst` for 1 cycle at cycle 6 of a conversion and require:
  - `busy`=0 and all outputs at 0 the next cycle;
  - no `done` pulse;
  - a fresh `start` then converting normally.
